// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong reorder buffer for a 512-point FFT carried as
// 32 beats of 16 complex lanes. Beats arrive in bit-reversed position order
// and leave in natural order: output beat k, lane m reads position
// bitrev9(k*16+m) of the bank being drained.
//
// Handshake: a beat moves on a rising clk edge exactly when valid && ready
// are both high on that side. valid never depends on ready. While
// dout_valid=1 and dout_ready=0, dout and the sof/eof markers hold still.
// din_ready depends only on the write bank state, and dout_valid depends
// only on the read bank state.
module fft_reorder_buf #(
  parameter int W = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] din_re [0:15],
  input  logic signed [W-1:0] din_im [0:15],
  input  logic                din_valid,
  input  logic                din_sof,
  output logic                din_ready,
  output logic signed [W-1:0] dout_re [0:15],
  output logic signed [W-1:0] dout_im [0:15],
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_sof,
  output logic                dout_eof,
  output logic [3:0]          dbg_bank_state
);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Per-bank lifecycle state, write/read bank selects and beat counters.
  bank_state_e bank_state_q [0:1];
  bank_state_e bank_state_d [0:1];
  logic        wsel_q, wsel_d;
  logic        rsel_q, rsel_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [4:0]  rcnt_q, rcnt_d;

  // Storage for both banks: address = {bank, position[8:0]}.
  logic signed [W-1:0] mem_re [0:1023];
  logic signed [W-1:0] mem_im [0:1023];

  logic       wr_en;
  logic       rd_xfer;
  logic       resync;
  logic [4:0] wr_beat;
  logic [9:0] rd_addr [0:15];

  function automatic logic [3:0] rev4(input logic [3:0] v);
    rev4 = {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [4:0] rev5(input logic [4:0] v);
    rev5 = {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // Handshake qualifiers; a sof on a non-zero wcnt restarts the frame.
  always_comb begin
    din_ready  = (bank_state_q[wsel_q] == BANK_EMPTY) ||
                 (bank_state_q[wsel_q] == BANK_FILLING);
    dout_valid = (bank_state_q[rsel_q] == BANK_FULL) ||
                 (bank_state_q[rsel_q] == BANK_DRAINING);
    wr_en      = din_valid && din_ready;
    rd_xfer    = dout_valid && dout_ready;
    resync     = din_sof && (wcnt_q != 5'd0);
    wr_beat    = din_sof ? 5'd0 : wcnt_q;
  end

  // Next-state for both bank FSMs, selects and counters. The write side and
  // read side always target different banks when both are active, so a
  // fill-complete and a drain-complete in the same cycle both take effect.
  always_comb begin
    bank_state_d[0] = bank_state_q[0];
    bank_state_d[1] = bank_state_q[1];
    wsel_d          = wsel_q;
    rsel_d          = rsel_q;
    wcnt_d          = wcnt_q;
    rcnt_d          = rcnt_q;

    for (int b = 0; b < 2; b++) begin
      if (wr_en && (wsel_q == b[0])) begin
        if (resync) begin
          bank_state_d[b] = BANK_FILLING;
        end else if (wcnt_q == 5'd31) begin
          bank_state_d[b] = BANK_FULL;
        end else begin
          bank_state_d[b] = BANK_FILLING;
        end
      end
      if (rd_xfer && (rsel_q == b[0])) begin
        if (rcnt_q == 5'd31) begin
          bank_state_d[b] = BANK_EMPTY;
        end else begin
          bank_state_d[b] = BANK_DRAINING;
        end
      end
    end

    if (wr_en) begin
      if (resync) begin
        wcnt_d = 5'd1;
      end else if (wcnt_q == 5'd31) begin
        wcnt_d = 5'd0;
        wsel_d = ~wsel_q;
      end else begin
        wcnt_d = wcnt_q + 5'd1;
      end
    end

    if (rd_xfer) begin
      if (rcnt_q == 5'd31) begin
        rcnt_d = 5'd0;
        rsel_d = ~rsel_q;
      end else begin
        rcnt_d = rcnt_q + 5'd1;
      end
    end
  end

  // Control state register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
      wsel_q          <= 1'b0;
      rsel_q          <= 1'b0;
      wcnt_q          <= 5'd0;
      rcnt_q          <= 5'd0;
    end else begin
      bank_state_q[0] <= bank_state_d[0];
      bank_state_q[1] <= bank_state_d[1];
      wsel_q          <= wsel_d;
      rsel_q          <= rsel_d;
      wcnt_q          <= wcnt_d;
      rcnt_q          <= rcnt_d;
    end
  end

  // Sample storage: one accepted beat writes 16 consecutive positions.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 16; l++) begin
        mem_re[{wsel_q, wr_beat, 4'(l)}] <= din_re[l];
        mem_im[{wsel_q, wr_beat, 4'(l)}] <= din_im[l];
      end
    end
  end

  // Read addresses: bitrev9(k*16+m) = {rev4(m), rev5(k)}.
  always_comb begin
    for (int m = 0; m < 16; m++) begin
      rd_addr[m] = {rsel_q, rev4(4'(m)), rev5(rcnt_q)};
    end
  end

  // Combinational output read and frame markers.
  always_comb begin
    for (int m = 0; m < 16; m++) begin
      dout_re[m] = mem_re[rd_addr[m]];
      dout_im[m] = mem_im[rd_addr[m]];
    end
    dout_sof       = dout_valid && (rcnt_q == 5'd0);
    dout_eof       = dout_valid && (rcnt_q == 5'd31);
    dbg_bank_state = {bank_state_q[1], bank_state_q[0]};
  end

endmodule

// File: doc/fft_reorder_buf.md
FFT_REORDER_BUF -- requirements
Module: fft_reorder_buf

Interface
REQ-001 SHALL have parameter W, default 15, giving the signed sample width of each real or imaginary part.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din_re[0:15], input, signed W each: real parts of one 16-lane beat in bit-reversed order.
REQ-005 SHALL have port din_im[0:15], input, signed W each: imaginary parts of the same beat.
REQ-006 SHALL have port din_valid, input, 1 bit: the din beat is valid.
REQ-007 SHALL have port din_sof, input, 1 bit: the din beat is beat 0 of a frame.
REQ-008 SHALL have port din_ready, output, 1 bit: the block can accept a beat.
REQ-009 SHALL have port dout_re[0:15] and dout_im[0:15], output, signed W each: one 16-lane beat in natural order.
REQ-010 SHALL have port dout_valid, output, 1 bit: the dout beat is valid.
REQ-011 SHALL have port dout_ready, input, 1 bit: the sink accepts the dout beat.
REQ-012 SHALL have port dout_sof and dout_eof, output, 1 bit each: marks output beat 0 and output beat 31.

Function
REQ-013 SHALL treat one frame as 512 complex points carried in 32 beats of 16 lanes.
REQ-014 SHALL define input position p = wcnt*16 + lane, where wcnt is 0..31.
REQ-015 SHALL hold two banks, B0 and B1, each of 512 complex words, plus a write-bank select wsel and a read-bank select rsel.
REQ-016 SHALL give each bank a state: EMPTY, FILLING, FULL or DRAINING.
REQ-017 SHALL assert din_ready = 1 exactly when bank[wsel] is EMPTY or FILLING.
REQ-018 SHALL define a write as din_valid && din_ready; on each write it stores lane l at position p of bank[wsel] and increments 5-bit wcnt.
REQ-019 SHALL move a bank EMPTY->FILLING on the first write and FILLING->FULL on the write with wcnt=31; on that write it toggles wsel and clears wcnt.
REQ-020 SHALL, on a write with din_sof=1 while wcnt!=0, discard the partial frame: the beat is stored as beat 0 and wcnt becomes 1.
REQ-021 SHALL ignore din_sof=1 when wcnt=0; that beat is stored normally as beat 0.
REQ-022 SHALL ignore din_sof when din_valid=0.
REQ-023 SHALL assert dout_valid = 1 exactly when bank[rsel] is FULL or DRAINING.
REQ-024 SHALL drive output beat k, lane m (k = 5-bit rcnt) from bank[rsel] position bitrev9(k*16+m), where bitrev9 reverses 9 bits.
REQ-025 SHALL drive dout as a combinational read of storage indexed by rcnt, with no extra register stage.
REQ-026 SHALL define a transfer as dout_valid && dout_ready; on each transfer it increments rcnt and sets the bank to DRAINING.
REQ-027 SHALL, on the transfer with rcnt=31, set the bank to EMPTY, toggle rsel and clear rcnt.
REQ-028 SHALL hold dout and the markers stable while dout_valid=1 and dout_ready=0.
REQ-029 SHALL assert dout_sof = dout_valid && rcnt==0 and dout_eof = dout_valid && rcnt==31.
REQ-030 SHALL assert the first dout_valid of a frame one cycle after the write with wcnt=31, provided bank[rsel] was that bank.
REQ-031 SHALL allow a write-complete on one bank and a read-complete on the other bank in the same cycle, with both transitions taking effect.
REQ-032 SHALL, when a bank goes EMPTY in cycle T, assert din_ready in cycle T+1.
REQ-033 SHALL sustain full throughput (one beat per clock in and out) with dout_ready held at 1.
REQ-034 SHALL pass data bit-exact; no arithmetic, rounding or saturation is applied.

Reset
REQ-035 SHALL, while rst=0, set both banks EMPTY, wsel=rsel=0 and wcnt=rcnt=0.
REQ-036 SHALL, while rst=0, drive din_ready=1, dout_valid=0, dout_sof=0 and dout_eof=0.
REQ-037 SHALL leave storage contents undefined after reset; they are never observable while dout_valid=0.
REQ-038 SHALL, on reset during a fill or drain, abandon the frame; the first frame after release starts at wcnt=0.

Verification
REQ-039 SHALL cover a ramp frame: din_re at position p = p, din_im = -p, dout_ready=1 -> beat 0 lanes 0,1,2 have re = 0,256,128; beat 1 lane 1 has re = 272 and im = -272; dout_sof and dout_eof each pulse once.
REQ-040 SHALL cover back-to-back streaming: 4 frames, din_valid and dout_ready held at 1 -> din_ready never drops, 128 output beats are contiguous, and first dout_valid occurs one cycle after the input beat-31 write.
REQ-041 SHALL cover backpressure: dout_ready=0 while 3 frames are offered -> din_ready drops after 64 accepted beats; raising dout_ready drains frame 1, then accepts frame 3 with data intact.
REQ-042 SHALL cover resync: din_sof at input beat 10 of a frame -> the output frame contains only the 32 beats from that sof onward.
REQ-043 SHALL cover reset mid-drain: rst pulsed low at output beat 12 -> dout_valid=0 and din_ready=1 immediately; the next full frame is output correctly from beat 0.
REQ-044 SHALL cover extremes: all lanes at +(2^(W-1)-1) and -2^(W-1), W=15 -> outputs are exactly 16383 and -16384 in the mapped positions.
